// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//
// Contents:
//   UART_CLKS_PER_BIT   default i_clk cycles per serial bit
//   UART_NUM_DATA_BITS  default data bits per frame (5..8)
//   UART_CNT_W          width of the per-bit clock counter
//   UART_BIT_IDX_W      width of the data-bit index (enough for 8 bits)
//   uart_state_e        receiver state encodings
package uart_pkg;

    localparam int UART_CLKS_PER_BIT  = 217;
    localparam int UART_NUM_DATA_BITS = 8;
    localparam int UART_CNT_W         = 16;
    localparam int UART_BIT_IDX_W     = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        CLEANUP    = 3'd5
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous input bit.
//
// Parameters:
//   RESET_VAL  value both flops take while i_reset is high
// Ports:
//   i_clk    destination clock
//   i_reset  asynchronous, active-high reset
//   i_d      asynchronous input
//   o_q      synchronized output (two i_clk cycles of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver: 1 start bit, NUM_DATA_BITS data bits (LSB first),
// optional even parity bit, 1 stop bit.
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after
// the data bits and report mismatches on o_parityError. Without it there is
// no parity state or logic and o_parityError is tied low.
//
// Parameters:
//   CLKS_PER_BIT   i_clk cycles per serial bit (<= 65535)
//   NUM_DATA_BITS  data bits per frame (5..8)
// Ports:
//   i_clk           system clock (rising edge)
//   i_reset         asynchronous, active-high reset
//   i_rx            asynchronous serial input, idle high
//   o_rxByte        last received data word; changes only on the strobe cycle
//   o_rxDoneStrobe  one-cycle pulse per completed frame (errors included)
//   o_rxActive      high from start-bit detect until back in IDLE
//   o_frameError    stop bit was low in the last frame
//   o_parityError   parity mismatch in the last frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = UART_CLKS_PER_BIT,
    parameter int NUM_DATA_BITS = UART_NUM_DATA_BITS
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_rx,
    output logic [NUM_DATA_BITS-1:0] o_rxByte,
    output logic                     o_rxDoneStrobe,
    output logic                     o_rxActive,
    output logic                     o_frameError,
    output logic                     o_parityError
);

    // The start bit is checked half a bit in; every later sample is a full
    // bit after the previous one, so all samples land mid-bit.
    localparam logic [UART_CNT_W-1:0]     HALF_BIT = UART_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [UART_CNT_W-1:0]     FULL_BIT = UART_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(NUM_DATA_BITS - 1);

    logic rx_sync;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_sync)
    );

    uart_state_e               state_q,   state_d;
    logic [UART_CNT_W-1:0]     count_q,   count_d;
    logic [UART_BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [NUM_DATA_BITS-1:0]  shift_q,   shift_d;
    logic [NUM_DATA_BITS-1:0]  byte_q,    byte_d;
    logic                      strobe_q,  strobe_d;
    logic                      active_q,  active_d;
    logic                      frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                      parity_bit_q, parity_bit_d;
    logic                      parity_err_q, parity_err_d;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            strobe_q     <= 1'b0;
            active_q     <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            strobe_q     <= strobe_d;
            active_q     <= active_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        strobe_d     = 1'b0;
        active_d     = active_q;
        frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = parity_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    state_d  = START_BIT;
                    count_d  = '0;
                    active_d = 1'b1;
                end
            end

            START_BIT: begin
                if (count_q == HALF_BIT) begin
                    count_d = '0;
                    if (!rx_sync) begin
                        state_d   = DATA_BITS;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            DATA_BITS: begin
                if (count_q == FULL_BIT) begin
                    count_d = '0;
                    shift_d[bit_idx_q] = rx_sync;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY_BIT;
`else
                        state_d   = STOP_BIT;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY_BIT: begin
                if (count_q == FULL_BIT) begin
                    count_d      = '0;
                    parity_bit_d = rx_sync;
                    state_d      = STOP_BIT;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
`endif

            STOP_BIT: begin
                if (count_q == FULL_BIT) begin
                    count_d     = '0;
                    byte_d      = shift_q;
                    frame_err_d = ~rx_sync;
`ifdef UART_RX_PARITY_EN
                    // Even parity: data bits plus parity bit must XOR to 0.
                    parity_err_d = (^shift_q) ^ parity_bit_q;
`endif
                    strobe_d    = 1'b1;
                    state_d     = CLEANUP;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            CLEANUP: begin
                // A low stop bit or a break keeps us here, so the tail of a
                // bad frame is never mistaken for a new start bit.
                if (rx_sync) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    assign o_rxByte       = byte_q;
    assign o_rxDoneStrobe = strobe_q;
    assign o_rxActive     = active_q;
    assign o_frameError   = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign o_parityError  = parity_err_q;
`else
    assign o_parityError  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx (CLKS_PER_BIT=217,
// 8 data bits). Builds with or without UART_RX_PARITY_EN; the parity bit is
// driven and checked only when the macro is defined.
module tb_uart_rx;

    localparam int CPB = 217;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rx;
    logic [7:0] o_rxByte;
    logic       o_rxDoneStrobe;
    logic       o_rxActive;
    logic       o_frameError;
    logic       o_parityError;

    uart_rx #(
        .CLKS_PER_BIT  (CPB),
        .NUM_DATA_BITS (8)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx           (i_rx),
        .o_rxByte       (o_rxByte),
        .o_rxDoneStrobe (o_rxDoneStrobe),
        .o_rxActive     (o_rxActive),
        .o_frameError   (o_frameError),
        .o_parityError  (o_parityError)
    );

    always #5 i_clk = ~i_clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cycle = 0;
    int         strobe_cnt = 0;
    int         strobe_cycle = 0;
    int         stop_start_cycle = 0;
    logic [7:0] cap_q[$];
    logic [7:0] prev_byte = 8'h00;
    logic       prev_strobe = 1'b0;

    always @(posedge i_clk) cycle++;

    // Strobe capture plus two continuous properties: the strobe is a single
    // cycle wide and o_rxByte only moves on a strobe cycle.
    always @(negedge i_clk) begin
        if (i_reset) begin
            prev_byte   = o_rxByte;
            prev_strobe = 1'b0;
        end else begin
            if (o_rxDoneStrobe) begin
                strobe_cnt++;
                strobe_cycle = cycle;
                cap_q.push_back(o_rxByte);
                n_cmp++;
                if (prev_strobe) begin
                    n_fail++;
                    $display("FAIL strobe_width: strobe high on consecutive cycles, want 1-cycle pulse");
                end
            end else if (o_rxByte !== prev_byte) begin
                n_cmp++;
                n_fail++;
                $display("FAIL byte_stable: o_rxByte %h changed from %h without strobe", o_rxByte, prev_byte);
            end
            prev_byte   = o_rxByte;
            prev_strobe = o_rxDoneStrobe;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic drive_bits(input logic v, input int nbits);
        i_rx = v;
        tick(nbits * CPB);
    endtask

    // One frame: start, data LSB first, optional parity, stop held stop_bits
    // bit times at stop_val. Leaves the line at stop_val.
    task automatic send_frame(input logic [7:0] data, input logic par,
                              input logic stop_val, input int stop_bits);
        drive_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bits(data[i], 1);
`ifdef UART_RX_PARITY_EN
        drive_bits(par, 1);
`else
        if (par === 1'bx) $display("parity bit undefined");
`endif
        stop_start_cycle = cycle;
        drive_bits(stop_val, stop_bits);
        $display("frame data=%h par=%b stop=%b x%0d sent, strobes=%0d", data, par, stop_val, stop_bits, strobe_cnt);
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_rx    = 1'b1;
        tick(5);
        n_cmp++; if (o_rxByte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h want 00", o_rxByte); end
        n_cmp++; if (o_rxDoneStrobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", o_rxDoneStrobe); end
        n_cmp++; if (o_rxActive !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", o_rxActive); end
        n_cmp++; if (o_frameError !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", o_frameError); end
        n_cmp++; if (o_parityError !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", o_parityError); end
        i_reset = 1'b0;
        tick(10);
        $display("reset sequence done");
    endtask

    task automatic test_basic;
        int s0;
        int dt;
        s0 = strobe_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        tick(CPB);
        dt = strobe_cycle - stop_start_cycle;
        n_cmp++; if (strobe_cnt !== s0 + 1) begin n_fail++; $display("FAIL basic_strobes: got %0d want %0d", strobe_cnt - s0, 1); end
        n_cmp++; if (o_rxByte !== 8'hA5) begin n_fail++; $display("FAIL basic_byte: got %h want a5", o_rxByte); end
        n_cmp++; if (o_frameError !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", o_frameError); end
        n_cmp++; if (o_parityError !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", o_parityError); end
        // Stop sampled ~110 cycles into the bit, seen through 2 sync flops.
        n_cmp++; if (dt < 110 || dt > 114) begin n_fail++; $display("FAIL basic_timing: strobe %0d cycles after stop start, want 110..114", dt); end
        n_cmp++; if (o_rxActive !== 1'b0) begin n_fail++; $display("FAIL basic_idle: active %b want 0", o_rxActive); end
    endtask

    task automatic test_glitch;
        int s0;
        s0 = strobe_cnt;
        i_rx = 1'b0;
        tick(20);
        n_cmp++; if (o_rxActive !== 1'b1) begin n_fail++; $display("FAIL glitch_active_on: got %b want 1", o_rxActive); end
        tick(30);
        i_rx = 1'b1;
        tick(50);
        n_cmp++; if (o_rxActive !== 1'b1) begin n_fail++; $display("FAIL glitch_active_100: got %b want 1", o_rxActive); end
        tick(20);
        n_cmp++; if (o_rxActive !== 1'b0) begin n_fail++; $display("FAIL glitch_active_off: got %b want 0", o_rxActive); end
        tick(3 * CPB);
        n_cmp++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL glitch_strobe: got %0d strobes want 0", strobe_cnt - s0); end
        $display("glitch pulse of 50 cycles applied");
    endtask

    task automatic test_frame_error;
        int s0;
        s0 = strobe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1);
        n_cmp++; if (strobe_cnt !== s0 + 1) begin n_fail++; $display("FAIL ferr_strobes: got %0d want 1", strobe_cnt - s0); end
        n_cmp++; if (o_rxByte !== 8'h3C) begin n_fail++; $display("FAIL ferr_byte: got %h want 3c", o_rxByte); end
        n_cmp++; if (o_frameError !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", o_frameError); end
        drive_bits(1'b0, 2);
        n_cmp++; if (o_rxActive !== 1'b1) begin n_fail++; $display("FAIL ferr_cleanup_active: got %b want 1", o_rxActive); end
        n_cmp++; if (o_frameError !== 1'b1) begin n_fail++; $display("FAIL ferr_held: got %b want 1", o_frameError); end
        drive_bits(1'b1, 2);
        n_cmp++; if (o_rxActive !== 1'b0) begin n_fail++; $display("FAIL ferr_release_active: got %b want 0", o_rxActive); end
        n_cmp++; if (strobe_cnt !== s0 + 1) begin n_fail++; $display("FAIL ferr_no_new_frame: got %0d strobes want 1", strobe_cnt - s0); end
        send_frame(8'h55, 1'b0, 1'b1, 1);
        n_cmp++; if (strobe_cnt !== s0 + 2) begin n_fail++; $display("FAIL ferr_next_strobes: got %0d want 2", strobe_cnt - s0); end
        n_cmp++; if (o_rxByte !== 8'h55) begin n_fail++; $display("FAIL ferr_next_byte: got %h want 55", o_rxByte); end
        n_cmp++; if (o_frameError !== 1'b0) begin n_fail++; $display("FAIL ferr_next_flag: got %b want 0", o_frameError); end
    endtask

    task automatic test_reset_mid_frame;
        int s0;
        s0 = strobe_cnt;
        drive_bits(1'b0, 1);
        drive_bits(1'b1, 4);
        i_reset = 1'b1;
        i_rx    = 1'b1;
        tick(3);
        n_cmp++; if (o_rxByte !== 8'h00) begin n_fail++; $display("FAIL midrst_byte: got %h want 00", o_rxByte); end
        n_cmp++; if (o_rxActive !== 1'b0) begin n_fail++; $display("FAIL midrst_active: got %b want 0", o_rxActive); end
        n_cmp++; if (o_frameError !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr: got %b want 0", o_frameError); end
        n_cmp++; if (o_parityError !== 1'b0) begin n_fail++; $display("FAIL midrst_perr: got %b want 0", o_parityError); end
        i_reset = 1'b0;
        tick(8 * CPB);
        n_cmp++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL midrst_no_strobe: got %0d strobes want 0", strobe_cnt - s0); end
        $display("reset applied after data bit 3 of ff");
        send_frame(8'h12, 1'b0, 1'b1, 1);
        n_cmp++; if (strobe_cnt !== s0 + 1) begin n_fail++; $display("FAIL midrst_next_strobes: got %0d want 1", strobe_cnt - s0); end
        n_cmp++; if (o_rxByte !== 8'h12) begin n_fail++; $display("FAIL midrst_next_byte: got %h want 12", o_rxByte); end
    endtask

    task automatic test_parity;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1);
        n_cmp++; if (o_rxByte !== 8'h07) begin n_fail++; $display("FAIL par_good_byte: got %h want 07", o_rxByte); end
        n_cmp++; if (o_parityError !== 1'b0) begin n_fail++; $display("FAIL par_good: got %b want 0", o_parityError); end
        send_frame(8'h07, 1'b0, 1'b1, 1);
        n_cmp++; if (o_parityError !== 1'b1) begin n_fail++; $display("FAIL par_bad: got %b want 1", o_parityError); end
        n_cmp++; if (o_frameError !== 1'b0) begin n_fail++; $display("FAIL par_bad_ferr: got %b want 0", o_frameError); end
`else
        send_frame(8'h07, 1'b0, 1'b1, 1);
        n_cmp++; if (o_rxByte !== 8'h07) begin n_fail++; $display("FAIL nopar_byte: got %h want 07", o_rxByte); end
        n_cmp++; if (o_parityError !== 1'b0) begin n_fail++; $display("FAIL nopar_perr: got %b want 0", o_parityError); end
`endif
    endtask

    task automatic test_back_to_back;
        int s0;
        int n0;
        s0 = strobe_cnt;
        n0 = cap_q.size();
        send_frame(8'h00, 1'b0, 1'b1, 1);
        send_frame(8'hFF, 1'b0, 1'b1, 1);
        tick(CPB);
        n_cmp++; if (strobe_cnt !== s0 + 2) begin n_fail++; $display("FAIL b2b_strobes: got %0d want 2", strobe_cnt - s0); end
        if (cap_q.size() >= n0 + 2) begin
            n_cmp++; if (cap_q[n0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h want 00", cap_q[n0]); end
            n_cmp++; if (cap_q[n0+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h want ff", cap_q[n0+1]); end
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL b2b_capture: got %0d bytes want 2", cap_q.size() - n0);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_rx    = 1'b1;
        tick(1);
        test_reset;
        test_basic;
        test_glitch;
        test_frame_error;
        test_reset_mid_frame;
        test_parity;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
